// File: rtl/verin_pwm_ctrl.sv
// Actuator (verin) drive: PWM + direction from latched freq/duty/sens, end-stop cut-off,
// and a periodic 3-byte status frame (flags, angle) written to the processor over write_data/write_n.
module verin_pwm_ctrl #(
  parameter int unsigned STATUS_PERIOD = 50000,
  parameter int unsigned ANGLE_W       = 12,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   freq,
  input  logic [CNT_W-1:0]   duty,
  input  logic               sens_in,
  input  logic [ANGLE_W-1:0] angle_barre,
  input  logic [ANGLE_W-1:0] butee_g,
  input  logic [ANGLE_W-1:0] butee_d,
  output logic               pwm_out,
  output logic               sens_out,
  output logic               fin_course_g,
  output logic               fin_course_d,
  output logic [7:0]         write_data,
  output logic               write_n
);

  localparam int unsigned TW = (STATUS_PERIOD > 1) ? $clog2(STATUS_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   freq_l_q, freq_l_d;
  logic [CNT_W-1:0]   duty_l_q, duty_l_d;
  logic               sens_l_q, sens_l_d;
  logic               fc_g_q, fc_d_q;
  logic               pwm_q, pwm_d;
  logic               period_end, raw_pwm, blocked;

  logic [TW-1:0]      timer_q, timer_d;
  logic               start;
  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [ANGLE_W-1:0] snap_angle_q, snap_angle_d;
  logic [3:0]         snap_flags_q, snap_flags_d;
  logic [11:0]        angle12;
  logic [7:0]         byte_sel;
  logic [7:0]         wdata_q, wdata_d;
  logic               wn_q, wn_d;

  // PWM period engine: settings only reload at a period boundary (or continuously while stopped)
  always_comb begin
    period_end = (freq_l_q == '0) || (cnt_q == freq_l_q - CNT_W'(1));
    raw_pwm    = (freq_l_q != '0) && (cnt_q < duty_l_q);
    blocked    = (sens_l_q & fc_d_q) | (~sens_l_q & fc_g_q);
    pwm_d      = raw_pwm & ~blocked;
    cnt_d      = cnt_q + CNT_W'(1);
    freq_l_d   = freq_l_q;
    duty_l_d   = duty_l_q;
    sens_l_d   = sens_l_q;
    if (period_end) begin
      cnt_d    = '0;
      freq_l_d = freq;
      duty_l_d = duty;
      sens_l_d = sens_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      freq_l_q <= '0;
      duty_l_q <= '0;
      sens_l_q <= 1'b0;
      fc_g_q   <= 1'b0;
      fc_d_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      freq_l_q <= freq_l_d;
      duty_l_q <= duty_l_d;
      sens_l_q <= sens_l_d;
      fc_g_q   <= (angle_barre <= butee_g);
      fc_d_q   <= (angle_barre >= butee_d);
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign sens_out     = sens_l_q;
  assign fin_course_g = fc_g_q;
  assign fin_course_d = fc_d_q;

  // Zero-fill the snapshot angle to the 12-bit frame layout
  for (genvar gi = 0; gi < 12; gi++) begin : g_angle12
    if (gi < ANGLE_W) begin : g_bit
      assign angle12[gi] = snap_angle_d[gi];
    end else begin : g_zero
      assign angle12[gi] = 1'b0;
    end
  end

  assign start   = (timer_q == TW'(STATUS_PERIOD - 1));
  assign timer_d = start ? '0 : timer_q + TW'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_angle_d = snap_angle_q;
    snap_flags_d = snap_flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_angle_d = angle_barre;
          snap_flags_d = {fc_d_q, fc_g_q, sens_l_q, (freq_l_q != '0) & ~blocked};
          idx_d        = 2'd0;
          state_d      = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (idx_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = SETUP;
        end
      end
      default: state_d = IDLE;
    endcase

    case (idx_d)
      2'd0:    byte_sel = {4'hA, snap_flags_d};
      2'd1:    byte_sel = {4'h0, angle12[11:8]};
      default: byte_sel = angle12[7:0];
    endcase

    // Data changes only on entry to SETUP, so it is stable around the strobe and holds in IDLE
    wdata_d = (state_d == SETUP) ? byte_sel : wdata_q;
    wn_d    = (state_d != STROBE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q      <= '0;
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      snap_angle_q <= '0;
      snap_flags_q <= 4'h0;
      wdata_q      <= 8'h00;
      wn_q         <= 1'b1;
    end else begin
      timer_q      <= timer_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_angle_q <= snap_angle_d;
      snap_flags_q <= snap_flags_d;
      wdata_q      <= wdata_d;
      wn_q         <= wn_d;
    end
  end

  assign write_data = wdata_q;
  assign write_n    = wn_q;

endmodule

// File: tb/tb_verin_pwm_ctrl.sv
// Scoreboard bench for verin_pwm_ctrl: a period-level model predicts pin levels and status
// frames; a negedge monitor pops and compares them against the DUT.
module tb_verin_pwm_ctrl;
  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] freq = '0, duty = '0;
  logic        sens_in = 1'b0;
  logic [11:0] angle_barre = '0, butee_g = '0, butee_d = '0;
  logic        pwm_out, sens_out, fin_course_g, fin_course_d, write_n;
  logic [7:0]  write_data;

  verin_pwm_ctrl #(.STATUS_PERIOD(P), .ANGLE_W(12), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .freq(freq), .duty(duty), .sens_in(sens_in),
    .angle_barre(angle_barre), .butee_g(butee_g), .butee_d(butee_d),
    .pwm_out(pwm_out), .sens_out(sens_out), .fin_course_g(fin_course_g),
    .fin_course_d(fin_course_d), .write_data(write_data), .write_n(write_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [4:0] q_pin[$];   // {pwm, sens, fc_g, fc_d, write_n} expected after each edge
  logic [7:0] q_bytes[$]; // expected status bytes in strobe order

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Reference model: position within the current PWM period, settings captured at period start
  int         per_len, per_high, pos;
  bit         per_sens, fcg_m, fcd_m;
  longint     edges;
  initial begin
    bit         blk, pwm_e, wn_e;
    logic [11:0] a;
    per_len = 0; per_high = 0; pos = 0; per_sens = 0; fcg_m = 0; fcd_m = 0; edges = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        per_len = 0; per_high = 0; pos = 0; per_sens = 0; fcg_m = 0; fcd_m = 0; edges = 0;
      end else begin
        blk = (per_sens && fcd_m) || (!per_sens && fcg_m);
        if (edges % P == P - 1) begin
          a = angle_barre;
          q_bytes.push_back({4'hA, fcd_m, fcg_m, per_sens, (per_len != 0) && !blk});
          q_bytes.push_back({4'h0, a[11:8]});
          q_bytes.push_back(a[7:0]);
        end
        pwm_e = (per_len != 0) && (pos < per_high) && !blk;
        if (per_len == 0 || pos == per_len - 1) begin
          per_len = int'(freq); per_high = int'(duty); per_sens = sens_in; pos = 0;
        end else begin
          pos++;
        end
        fcd_m = (angle_barre >= butee_d);
        fcg_m = (angle_barre <= butee_g);
        wn_e  = !((edges >= P - 1) && (((edges + 1) % P) inside {1, 4, 7}));
        q_pin.push_back({pwm_e, per_sens, fcg_m, fcd_m, wn_e});
        edges++;
      end
    end
  end

  // Monitor
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (q_pin.size() > 0) begin
          e = q_pin.pop_front();
          check("pins", {3'b000, pwm_out, sens_out, fin_course_g, fin_course_d, write_n}, {3'b000, e});
        end
        if (write_n === 1'b0) begin
          if (q_bytes.size() == 0) check("unexpected_strobe", write_data, 8'hxx);
          else check("status_byte", write_data, q_bytes.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set(input int f, input int d, input bit s, input int a, input int g, input int bd);
    freq = 16'(f); duty = 16'(d); sens_in = s;
    angle_barre = 12'(a); butee_g = 12'(g); butee_d = 12'(bd);
  endtask

  initial begin
    bit seen;
    set(100, 25, 1, 2048, 100, 4000);
    #23;
    check("rst_pwm", {7'b0, pwm_out}, 8'h00);
    check("rst_sens", {7'b0, sens_out}, 8'h00);
    check("rst_fc", {6'b0, fin_course_g, fin_course_d}, 8'h00);
    check("rst_wdata", write_data, 8'h00);
    check("rst_wn", {7'b0, write_n}, 8'h01);
    @(negedge clk); #1 reset = 1'b0;

    cyc(150);                       // 25 high / 75 low, sens_out=1
    duty = 75; cyc(260);            // mid-period change applies next period
    freq = 0; cyc(60);
    freq = 100; duty = 120; cyc(220);
    for (int a = 3990; a <= 4010; a++) begin angle_barre = 12'(a); cyc(3); end
    cyc(20);
    sens_in = 0; cyc(220);          // reverse direction resumes PWM
    set(20, 7, 1, 12'h5A3, 100, 12'h500); cyc(80);

    for (int i = 0; i < 40; i++) begin
      set($urandom_range(0, 12), $urandom_range(0, 14), 1'($urandom_range(0, 1)),
          $urandom_range(0, 4095), $urandom_range(0, 2000), $urandom_range(1500, 4095));
      for (int j = 0; j < 30; j++) begin
        if ($urandom_range(0, 3) == 0) angle_barre = 12'($urandom_range(0, 4095));
        cyc(1);
      end
    end

    // Reset in the middle of a strobe
    set(10, 10, 1, 2000, 100, 4000); cyc(40);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (write_n === 1'b0) seen = 1;
    end
    check("strobe_seen", {7'b0, seen}, 8'h01);
    #1 reset = 1'b1;
    q_bytes.delete();
    #1;
    check("rst_mid_wn", {7'b0, write_n}, 8'h01);
    check("rst_mid_pwm", {7'b0, pwm_out}, 8'h00);
    cyc(3); #1 reset = 1'b0;
    cyc(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
